// File: rtl/op_pkg.sv
// Shared definitions for the primitive-recursive operator blocks.
`default_nettype none

package op_pkg;

    typedef enum logic [0:0] {
        OP_IDLE = 1'b0,
        OP_BUSY = 1'b1
    } op_state_t;

    // Bits needed to index 'value' distinct items (0 for a single item).
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/op_start_edge.sv
// Start-request rising-edge detector shared by all operator blocks.
`default_nettype none

module op_start_edge (
    input  logic CLK,
    input  logic RST,
    input  logic ST,
    output logic startev_o
);

    logic st_old_q;

    // Tracks ST even during reset, so ST held high across reset release is not an edge.
    always_ff @(posedge CLK) begin
        st_old_q <= ST;
    end

    assign startev_o = ST & ~st_old_q & ~RST;

endmodule

`default_nettype wire

// File: rtl/operation_i_sel.sv
// Run-time selectable projection operator: returns captured word SEL of NIN inputs after LAT cycles.
`default_nettype none

module operation_i_sel
    import op_pkg::*;
#(
    parameter int BW  = 16,
    parameter int NIN = 3,
    parameter int SW  = 2,
    parameter int LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ST,
    input  logic [SW-1:0]     SEL,
    input  logic [NIN*BW-1:0] IN,
    output logic              RD,
    output logic [BW-1:0]     RES,
    output logic              ERR
);

    localparam int CW = (LAT > 1) ? clog2(LAT) : 1;

    generate
        if ((SW < clog2(NIN)) || (NIN < 1) || (LAT < 1)) begin : g_param_check
            $error("operation_i_sel: illegal parameters (need NIN>=1, LAT>=1, 2**SW>=NIN)");
        end
    endgenerate

    op_state_t         state_q;
    logic [CW-1:0]     cnt_q;
    logic [SW-1:0]     sel_q;
    logic [NIN*BW-1:0] in_q;
    logic [BW-1:0]     res_q;
    logic              rd_q;
    logic              err_q;

    logic              startev;
    logic              in_range_d;
    logic [BW-1:0]     word_d;

    op_start_edge u_start_edge (
        .CLK       (CLK),
        .RST       (RST),
        .ST        (ST),
        .startev_o (startev)
    );

    // One extra bit so the compare still works when NIN == 2**SW.
    assign in_range_d = ({1'b0, sel_q} < (SW + 1)'(NIN));

    always_comb begin
        word_d = '0;
        for (int i = 0; i < NIN; i++) begin
            if (sel_q == SW'(i)) begin
                word_d = in_q[i*BW +: BW];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= OP_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            in_q    <= '0;
            res_q   <= '0;
            rd_q    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                OP_IDLE: begin
                    if (startev && rd_q) begin
                        sel_q   <= SEL;
                        in_q    <= IN;
                        cnt_q   <= CW'(LAT - 1);
                        rd_q    <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= OP_BUSY;
                    end
                end
                OP_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        res_q   <= in_range_d ? word_d : '0;
                        err_q   <= ~in_range_d;
                        rd_q    <= 1'b1;
                        state_q <= OP_IDLE;
                    end
                end
                default: begin
                    state_q <= OP_IDLE;
                    rd_q    <= 1'b1;
                end
            endcase
        end
    end

    assign RD  = rd_q;
    assign RES = res_q;
    assign ERR = err_q;

endmodule

`default_nettype wire
